link_word_receiver: RTL and testbench

- Receive-end decoder for the 10-bit noisy link. Consumes codewords after the channel stage.
- Validates a 2-bit checksum, enforces 2-bit sequence order, and delivers the 6-bit payload downstream.
- Returns ACK/NAK pulses to the transmitter.
- Raises sticky link_fail after too many consecutive bad words.

---
 rtl/link_word_receiver_if.sv | 26 ++
 rtl/link_word_receiver.sv | 134 +++++++++++++
 tb/tb_link_word_receiver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/link_word_receiver_if.sv
// Handshake and status bundle between the link channel stage and link_word_receiver.
interface link_word_receiver_if #(
  parameter int unsigned STAT_W = 8
) ();
  logic [9:0]        din;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        dout;
  logic              out_valid;
  logic              out_ready;
  logic              ack;
  logic              nak;
  logic [1:0]        exp_seq;
  logic              link_fail;
  logic [STAT_W-1:0] err_cnt;

  modport master (
    output din, in_valid, out_ready,
    input  in_ready, dout, out_valid, ack, nak, exp_seq, link_fail, err_cnt
  );

  modport slave (
    input  din, in_valid, out_ready,
    output in_ready, dout, out_valid, ack, nak, exp_seq, link_fail, err_cnt
  );
endinterface

// File: rtl/link_word_receiver.sv
// Receive-end decoder: checksum/sequence validation, payload delivery, ACK/NAK, sticky link_fail.
// Optional error counter built only when RX_STATS_EN is defined.
module link_word_receiver #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned STAT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  link_word_receiver_if.slave  lnk
);
  typedef enum logic [1:0] {IDLE, CHECK, DELIVER, NAK} state_t;

  state_t      r_state, w_state_nxt;
  logic [9:0]  r_word, w_word_nxt;
  logic [5:0]  r_dout, w_dout_nxt;
  logic        r_out_valid, w_out_valid_nxt;
  logic        r_ack, w_ack_nxt;
  logic        r_nak, w_nak_nxt;
  logic [1:0]  r_exp_seq, w_exp_seq_nxt;
  logic [3:0]  r_retry, w_retry_nxt;
  logic        r_link_fail, w_link_fail_nxt;

  logic        w_in_ready, w_accept, w_good, w_is_new, w_is_dup;
  logic [1:0]  w_seq;
  logic [4:0]  w_sum;
  logic [3:0]  w_retry_inc;

  // Word classification on the registered codeword.
  assign w_seq       = r_word[9:8];
  assign w_sum       = 5'(r_word[7:5]) + 5'(r_word[4:2]) + 5'(w_seq);
  assign w_good      = ((w_sum - 5'(r_word[1:0])) & 5'b00011) == 5'd0;
  assign w_is_new    = (w_seq == r_exp_seq);
  assign w_is_dup    = (w_seq == 2'(r_exp_seq - 2'd1));
  assign w_retry_inc = r_retry + 4'd1;
  assign w_in_ready  = (r_state == IDLE) && !r_link_fail;
  assign w_accept    = lnk.in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = CHECK;
      CHECK: begin
        if (w_good && w_is_new)      w_state_nxt = DELIVER;
        else if (w_good && w_is_dup) w_state_nxt = IDLE;
        else                         w_state_nxt = NAK;
      end
      DELIVER: if (lnk.out_ready) w_state_nxt = IDLE;
      NAK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_word_nxt      = r_word;
    w_dout_nxt      = r_dout;
    w_out_valid_nxt = r_out_valid;
    w_ack_nxt       = 1'b0;
    w_nak_nxt       = 1'b0;
    w_exp_seq_nxt   = r_exp_seq;
    w_retry_nxt     = r_retry;
    w_link_fail_nxt = r_link_fail;
    case (r_state)
      IDLE: if (w_accept) w_word_nxt = lnk.din;
      CHECK: begin
        if (w_good && w_is_new) begin
          w_dout_nxt      = r_word[7:2];
          w_out_valid_nxt = 1'b1;
        end else if (w_good && w_is_dup) begin
          w_ack_nxt = 1'b1;
        end
      end
      DELIVER: if (lnk.out_ready) begin
        w_out_valid_nxt = 1'b0;
        w_ack_nxt       = 1'b1;
        w_exp_seq_nxt   = r_exp_seq + 2'd1;
        w_retry_nxt     = 4'd0;
      end
      NAK: begin
        w_nak_nxt   = 1'b1;
        w_retry_nxt = w_retry_inc;
        if (w_retry_inc == 4'(MAX_RETRY)) w_link_fail_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word      <= '0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
      r_ack       <= 1'b0;
      r_nak       <= 1'b0;
      r_exp_seq   <= '0;
      r_retry     <= '0;
      r_link_fail <= 1'b0;
    end else begin
      r_word      <= w_word_nxt;
      r_dout      <= w_dout_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_ack       <= w_ack_nxt;
      r_nak       <= w_nak_nxt;
      r_exp_seq   <= w_exp_seq_nxt;
      r_retry     <= w_retry_nxt;
      r_link_fail <= w_link_fail_nxt;
    end
  end

`ifdef RX_STATS_EN
  logic [STAT_W-1:0] r_err_cnt;

  // Saturating count of rejected words; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_err_cnt <= '0;
    else if (r_state == NAK && r_err_cnt != '1)  r_err_cnt <= r_err_cnt + STAT_W'(1);
  end
  assign lnk.err_cnt = r_err_cnt;
`else
  assign lnk.err_cnt = '0;
`endif

  assign lnk.in_ready  = w_in_ready;
  assign lnk.dout      = r_dout;
  assign lnk.out_valid = r_out_valid;
  assign lnk.ack       = r_ack;
  assign lnk.nak       = r_nak;
  assign lnk.exp_seq   = r_exp_seq;
  assign lnk.link_fail = r_link_fail;
endmodule

// File: tb/tb_link_word_receiver.sv
// Self-checking bench for link_word_receiver: directed vector table, random words vs. a model, reset corners.
module tb_link_word_receiver;
  localparam int unsigned STAT_W    = 8;
  localparam int unsigned MAX_RETRY = 3;
  localparam int K_DELIVER = 0;
  localparam int K_DUP     = 1;
  localparam int K_NAK     = 2;

  logic clk;
  logic rst_n;
  link_word_receiver_if #(.STAT_W(STAT_W)) lnk ();

  link_word_receiver #(.MAX_RETRY(MAX_RETRY), .STAT_W(STAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .lnk   (lnk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state, kept in terms of the protocol rules.
  int m_exp   = 0;
  int m_retry = 0;
  int m_fail  = 0;
  int m_err   = 0;

  typedef struct {
    logic [9:0] din;
    int         delay;
    int         kind;
    int         exp_seq_after;
    int         fail_after;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic int classify(input logic [9:0] w, input int e);
    int s, seq;
    seq = int'(w[9:8]);
    s   = int'(w[7:5]) + int'(w[4:2]) + seq;
    if ((s % 4) != int'(w[1:0])) return K_NAK;
    if (seq == e)                return K_DELIVER;
    if (seq == ((e + 3) % 4))    return K_DUP;
    return K_NAK;
  endfunction

  function automatic int exp_err();
`ifdef RX_STATS_EN
    return (m_err > 255) ? 255 : m_err;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_exp = 0; m_retry = 0; m_fail = 0; m_err = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dout"},      lnk.dout, 0);
    check({tag, "_out_valid"}, lnk.out_valid, 0);
    check({tag, "_ack_nak"},   {lnk.ack, lnk.nak}, 0);
    check({tag, "_exp_seq"},   lnk.exp_seq, 0);
    check({tag, "_link_fail"}, lnk.link_fail, 0);
    check({tag, "_err_cnt"},   lnk.err_cnt, 0);
    check({tag, "_in_ready"},  lnk.in_ready, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Sends one word starting at a negedge and ends at a negedge with the receiver idle again.
  task automatic run_word(input logic [9:0] w, input int delay, input int kind);
    logic [5:0] held;
    check("in_ready_idle", lnk.in_ready, 1);
    lnk.din = w;
    lnk.in_valid = 1'b1;
    @(negedge clk);
    lnk.in_valid = 1'b0;
    lnk.din = 10'($urandom);
    check("check_cycle_quiet", {lnk.out_valid, lnk.ack, lnk.nak}, 0);
    check("check_cycle_busy", lnk.in_ready, 0);
    @(negedge clk);
    case (kind)
      K_DELIVER: begin
        check("deliver_valid", lnk.out_valid, 1);
        check("deliver_dout", lnk.dout, w[7:2]);
        held = w[7:2];
        for (int i = 0; i < delay; i++) begin
          @(negedge clk);
          check("bp_dout_stable", lnk.dout, held);
          check("bp_valid_held", lnk.out_valid, 1);
          check("bp_in_ready", lnk.in_ready, 0);
          check("bp_no_ack", lnk.ack, 0);
        end
        lnk.out_ready = 1'b1;
        @(negedge clk);
        lnk.out_ready = 1'b0;
        m_exp = (m_exp + 1) % 4;
        m_retry = 0;
        check("deliver_ack", {lnk.ack, lnk.nak}, 2'b10);
        check("deliver_valid_drop", lnk.out_valid, 0);
        check("deliver_exp_seq", lnk.exp_seq, m_exp);
        @(negedge clk);
        check("deliver_ack_single", lnk.ack, 0);
      end
      K_DUP: begin
        check("dup_ack", {lnk.ack, lnk.nak}, 2'b10);
        check("dup_no_valid", lnk.out_valid, 0);
        check("dup_exp_seq", lnk.exp_seq, m_exp);
        @(negedge clk);
        check("dup_ack_single", lnk.ack, 0);
        check("dup_still_no_valid", lnk.out_valid, 0);
      end
      default: begin
        check("nak_state_quiet", {lnk.ack, lnk.nak, lnk.out_valid}, 0);
        @(negedge clk);
        m_retry++;
        m_err++;
        if (m_retry == MAX_RETRY) m_fail = 1;
        check("nak_pulse", {lnk.ack, lnk.nak}, 2'b01);
        check("nak_no_valid", lnk.out_valid, 0);
        check("nak_exp_seq", lnk.exp_seq, m_exp);
        check("nak_link_fail", lnk.link_fail, m_fail);
        check("nak_in_ready", lnk.in_ready, (m_fail != 0) ? 0 : 1);
        check("nak_err_cnt", lnk.err_cnt, exp_err());
        @(negedge clk);
        check("nak_single", lnk.nak, 0);
      end
    endcase
  endtask

  function automatic logic [9:0] make_good(input int seq, input logic [5:0] d);
    int s;
    s = int'(d[5:3]) + int'(d[2:0]) + seq;
    return {2'(seq), d, 2'(s % 4)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [9:0] w;
    int pick;

    vecs[0] = '{10'h0AC, 0, K_DELIVER, 1, 0};
    vecs[1] = '{10'h180, 0, K_NAK,     1, 0};
    vecs[2] = '{10'h0AC, 0, K_DUP,     1, 0};
    vecs[3] = '{10'h1AD, 5, K_DELIVER, 2, 0};
    vecs[4] = '{10'h003, 0, K_NAK,     2, 0};
    vecs[5] = '{10'h180, 0, K_NAK,     2, 0};
    vecs[6] = '{10'h3FF, 0, K_NAK,     2, 1};

    rst_n = 1'b0;
    lnk.din = '0;
    lnk.in_valid = 1'b0;
    lnk.out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed table: good word, corruption, duplicate, backpressure, retry limit.
    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].din, vecs[i].delay, vecs[i].kind);
      check("vec_exp_seq", lnk.exp_seq, vecs[i].exp_seq_after);
      check("vec_link_fail", lnk.link_fail, vecs[i].fail_after);
    end

    // After link_fail, further words are ignored.
    lnk.din = 10'h0AC;
    lnk.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("fail_ignored_in_ready", lnk.in_ready, 0);
      check("fail_ignored_quiet", {lnk.ack, lnk.nak, lnk.out_valid}, 0);
      check("fail_sticky", lnk.link_fail, 1);
    end
    lnk.in_valid = 1'b0;
    do_reset();

    // out_ready high with nothing pending has no effect.
    lnk.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_ready_quiet", {lnk.ack, lnk.nak, lnk.out_valid}, 0);
      check("idle_ready_exp_seq", lnk.exp_seq, 0);
    end
    lnk.out_ready = 1'b0;

    // Random words against the model.
    for (int n = 0; n < 60; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 5)      w = make_good(m_exp, 6'($urandom));
      else if (pick < 7) w = make_good((m_exp + 3) % 4, 6'($urandom));
      else               w = 10'($urandom);
      run_word(w, int'($urandom_range(0, 3)), classify(w, m_exp));
      if (m_fail != 0) do_reset();
    end

    // Reset while a word is waiting in DELIVER.
    run_word(make_good(m_exp, 6'h15), 0, K_DELIVER);
    w = make_good(m_exp, 6'h2B);
    lnk.din = w;
    lnk.in_valid = 1'b1;
    @(negedge clk);
    lnk.in_valid = 1'b0;
    @(negedge clk);
    check("mid_deliver_valid", lnk.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_deliver_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("post_reset_no_valid", lnk.out_valid, 0);
    run_word(10'h0AC, 1, K_DELIVER);
    check("post_reset_exp_seq", lnk.exp_seq, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
